// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl.sv
// DAC transfer start sequencer: arm -> (optional external trigger) -> dac_sync pulse
// -> programmable delay -> data enable, with underflow accounting and fault stop.
module ad_ip_jesd204_tpl_dac_start_ctrl #(
    parameter int SYNC_CYCLES = 4,
    parameter int UNF_LIMIT   = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 link_clk,
    input  logic                 link_resetn,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic                 ext_sync_en,
    input  logic                 ext_sync,
    input  logic [7:0]           start_delay,
    input  logic                 unf_stop,
    input  logic                 clr_unf,
    input  logic                 link_ready,
    input  logic                 dac_dunf,
    output logic                 dac_sync,
    output logic                 data_gate,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] unf_count,
    output logic                 unf_fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        SYNC  = 3'd2,
        DELAY = 3'd3,
        RUN   = 3'd4
    } state_t;

    localparam logic [7:0]           SYNC_LAST = 8'(SYNC_CYCLES - 1);
    localparam logic [7:0]           UNF_LAST  = 8'(UNF_LIMIT - 1);
    localparam logic [7:0]           UNF_SAT   = 8'(UNF_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    state_t               state_reg, state_next;
    logic                 ext_sync_reg;
    logic [7:0]           phase_cnt_reg, phase_cnt_next;
    logic [7:0]           delay_len_reg, delay_len_next;
    logic [7:0]           cons_reg, cons_next;
    logic [CNT_WIDTH-1:0] unf_count_reg, unf_count_next;
    logic                 unf_fault_reg, unf_fault_next;

    logic unf_cycle;
    logic unf_trip;

    assign unf_cycle = (state_reg == RUN) && dac_dunf && link_ready;
    // A clear in the same cycle suppresses the trip as well as the count.
    assign unf_trip  = unf_cycle && !clr_unf && (cons_reg == UNF_LAST);

    always_comb begin
        state_next     = state_reg;
        delay_len_next = delay_len_reg;
        phase_cnt_next = phase_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (arm && !disarm) begin
                    state_next = ext_sync_en ? ARMED : SYNC;
                end
            end
            ARMED: begin
                if (ext_sync && !ext_sync_reg) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                if (phase_cnt_reg == SYNC_LAST) begin
                    delay_len_next = start_delay;
                    state_next     = (start_delay != 8'd0) ? DELAY : RUN;
                end
            end
            DELAY: begin
                if (phase_cnt_reg == delay_len_reg - 8'd1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (unf_trip && unf_stop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (disarm && state_reg != IDLE) begin
            state_next = IDLE;
        end

        // Shared phase counter restarts on every state change.
        if (state_next != state_reg) begin
            phase_cnt_next = 8'd0;
        end else if (state_reg == SYNC || state_reg == DELAY) begin
            phase_cnt_next = phase_cnt_reg + 8'd1;
        end
    end

    always_comb begin
        unf_count_next = unf_count_reg;
        unf_fault_next = unf_fault_reg;
        cons_next      = cons_reg;

        if (clr_unf) begin
            unf_count_next = '0;
            unf_fault_next = 1'b0;
            cons_next      = 8'd0;
        end else begin
            if (unf_cycle && unf_count_reg != CNT_MAX) begin
                unf_count_next = unf_count_reg + CNT_WIDTH'(1);
            end
            if (unf_trip) begin
                unf_fault_next = 1'b1;
            end
            if (!unf_cycle || state_next != RUN) begin
                cons_next = 8'd0;
            end else if (cons_reg != UNF_SAT) begin
                cons_next = cons_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            state_reg     <= IDLE;
            ext_sync_reg  <= 1'b0;
            phase_cnt_reg <= 8'd0;
            delay_len_reg <= 8'd0;
            cons_reg      <= 8'd0;
            unf_count_reg <= '0;
            unf_fault_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ext_sync_reg  <= ext_sync;
            phase_cnt_reg <= phase_cnt_next;
            delay_len_reg <= delay_len_next;
            cons_reg      <= cons_next;
            unf_count_reg <= unf_count_next;
            unf_fault_reg <= unf_fault_next;
        end
    end

    assign state     = state_reg;
    assign dac_sync  = (state_reg == SYNC);
    assign data_gate = (state_reg == RUN);
    assign unf_count = unf_count_reg;
    assign unf_fault = unf_fault_reg;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_start_ctrl.sv
// Scoreboard bench: two parameterisations share one stimulus stream; a phase/countdown
// reference model pushes expected outputs per edge, a negedge monitor pops and compares.
module tb_ad_ip_jesd204_tpl_dac_start_ctrl;

    logic       link_clk = 1'b0;
    logic       link_resetn = 1'b1;
    logic       arm = 1'b0, disarm = 1'b0, ext_sync_en = 1'b0, ext_sync = 1'b0;
    logic [7:0] start_delay = 8'd0;
    logic       unf_stop = 1'b0, clr_unf = 1'b0, link_ready = 1'b0, dac_dunf = 1'b0;

    logic        a_sync, a_gate, a_fault;
    logic [2:0]  a_state;
    logic [15:0] a_count;
    logic        b_sync, b_gate, b_fault;
    logic [2:0]  b_state;
    logic [3:0]  b_count;

    always #5 link_clk = ~link_clk;

    ad_ip_jesd204_tpl_dac_start_ctrl dut_a (
        .link_clk(link_clk), .link_resetn(link_resetn), .arm(arm), .disarm(disarm),
        .ext_sync_en(ext_sync_en), .ext_sync(ext_sync), .start_delay(start_delay),
        .unf_stop(unf_stop), .clr_unf(clr_unf), .link_ready(link_ready), .dac_dunf(dac_dunf),
        .dac_sync(a_sync), .data_gate(a_gate), .state(a_state), .unf_count(a_count),
        .unf_fault(a_fault)
    );

    ad_ip_jesd204_tpl_dac_start_ctrl #(.SYNC_CYCLES(3), .UNF_LIMIT(5), .CNT_WIDTH(4)) dut_b (
        .link_clk(link_clk), .link_resetn(link_resetn), .arm(arm), .disarm(disarm),
        .ext_sync_en(ext_sync_en), .ext_sync(ext_sync), .start_delay(start_delay),
        .unf_stop(unf_stop), .clr_unf(clr_unf), .link_ready(link_ready), .dac_dunf(dac_dunf),
        .dac_sync(b_sync), .data_gate(b_gate), .state(b_state), .unf_count(b_count),
        .unf_fault(b_fault)
    );

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // Reference model: phase number plus cycles-left countdown per instance.
    int P_SYNC[2] = '{4, 3};
    int P_LIM[2]  = '{16, 5};
    int P_MAX[2]  = '{65535, 15};
    int m_state[2], m_left[2], m_cnt[2], m_flt[2], m_streak[2], m_prev[2];

    typedef struct {
        int inst;
        int st;
        int cnt;
        int flt;
    } exp_t;
    exp_t sb_q[$];

    function automatic void model_reset(input int i);
        m_state[i] = 0; m_left[i] = 0; m_cnt[i] = 0;
        m_flt[i] = 0; m_streak[i] = 0; m_prev[i] = 0;
    endfunction

    function automatic void model_step(input int i);
        int  nxt;
        bit  uf, trip;
        if (!link_resetn) begin
            model_reset(i);
            return;
        end
        uf = (m_state[i] == 4) && dac_dunf && link_ready;
        trip = 0;
        if (clr_unf) begin
            m_cnt[i] = 0; m_flt[i] = 0; m_streak[i] = 0;
        end else if (uf) begin
            if (m_cnt[i] < P_MAX[i]) m_cnt[i]++;
            m_streak[i]++;
            if (m_streak[i] == P_LIM[i]) begin
                trip = 1;
                m_flt[i] = 1;
            end
        end else begin
            m_streak[i] = 0;
        end
        nxt = m_state[i];
        if (disarm && m_state[i] != 0) begin
            nxt = 0;
        end else begin
            case (m_state[i])
                0: if (arm && !disarm) begin
                    nxt = ext_sync_en ? 1 : 2;
                    m_left[i] = P_SYNC[i];
                end
                1: if (ext_sync && !m_prev[i]) begin
                    nxt = 2;
                    m_left[i] = P_SYNC[i];
                end
                2: begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        if (start_delay != 0) begin
                            nxt = 3;
                            m_left[i] = int'(start_delay);
                        end else begin
                            nxt = 4;
                        end
                    end
                end
                3: begin
                    m_left[i]--;
                    if (m_left[i] == 0) nxt = 4;
                end
                4: if (trip && unf_stop) nxt = 0;
                default: nxt = 0;
            endcase
        end
        m_prev[i] = int'(ext_sync);
        m_state[i] = nxt;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge link_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            e.inst = i; e.st = m_state[i]; e.cnt = m_cnt[i]; e.flt = m_flt[i];
            sb_q.push_back(e);
        end
    endtask

    task automatic pulse(input int which);
        case (which)
            0: arm = 1'b1;
            1: disarm = 1'b1;
            default: clr_unf = 1'b1;
        endcase
        tick();
        arm = 1'b0; disarm = 1'b0; clr_unf = 1'b0;
    endtask

    exp_t mon_e;
    always @(negedge link_clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.inst == 0) begin
                chk("a.state", int'(a_state), mon_e.st);
                chk("a.dac_sync", int'(a_sync), int'(mon_e.st == 2));
                chk("a.data_gate", int'(a_gate), int'(mon_e.st == 4));
                chk("a.unf_count", int'(a_count), mon_e.cnt);
                chk("a.unf_fault", int'(a_fault), mon_e.flt);
            end else begin
                chk("b.state", int'(b_state), mon_e.st);
                chk("b.dac_sync", int'(b_sync), int'(mon_e.st == 2));
                chk("b.data_gate", int'(b_gate), int'(mon_e.st == 4));
                chk("b.unf_count", int'(b_count), mon_e.cnt);
                chk("b.unf_fault", int'(b_fault), mon_e.flt);
            end
        end
    end

    task automatic async_reset_check();
        @(negedge link_clk);
        #2;
        link_resetn = 1'b0;
        #1;
        chk("async.a.state", int'(a_state), 0);
        chk("async.a.data_gate", int'(a_gate), 0);
        chk("async.a.dac_sync", int'(a_sync), 0);
        chk("async.a.unf_count", int'(a_count), 0);
        chk("async.a.unf_fault", int'(a_fault), 0);
        chk("async.b.state", int'(b_state), 0);
        chk("async.b.unf_count", int'(b_count), 0);
        model_reset(0);
        model_reset(1);
        tick();
        tick();
        link_resetn = 1'b1;
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        #2 link_resetn = 1'b0;
        repeat (3) tick();
        link_resetn = 1'b1;
        repeat (2) tick();

        // Immediate start, zero delay.
        pulse(0);
        repeat (7) tick();
        pulse(1);
        tick();

        // External trigger: held high gives no edge, then 0 -> 1 starts.
        ext_sync_en = 1'b1; ext_sync = 1'b1;
        tick();
        pulse(0);
        repeat (4) tick();
        ext_sync = 1'b0;
        tick();
        ext_sync = 1'b1;
        repeat (7) tick();
        pulse(1);
        ext_sync_en = 1'b0; ext_sync = 1'b0;

        // Delay captured on SYNC exit; later change ignored.
        start_delay = 8'd3;
        pulse(0);
        repeat (5) tick();
        start_delay = 8'd9;
        repeat (6) tick();

        // Sustained underflow trips fault and stops.
        unf_stop = 1'b1; dac_dunf = 1'b1; link_ready = 1'b1;
        repeat (16) tick();
        dac_dunf = 1'b0;
        repeat (2) tick();

        // One-cycle gap prevents the fault.
        pulse(2);
        start_delay = 8'd0;
        pulse(1);
        pulse(0);
        repeat (6) tick();
        dac_dunf = 1'b1;
        repeat (4) tick();
        dac_dunf = 1'b0;
        tick();
        dac_dunf = 1'b1;
        repeat (4) tick();
        dac_dunf = 1'b0;
        tick();
        dac_dunf = 1'b1;
        repeat (3) tick();
        dac_dunf = 1'b0;
        tick();

        // arm+disarm in IDLE, disarm during SYNC, clear during underflow.
        pulse(1);
        arm = 1'b1; disarm = 1'b1;
        tick();
        arm = 1'b0; disarm = 1'b0;
        tick();
        pulse(0);
        tick();
        pulse(1);
        tick();
        pulse(0);
        repeat (6) tick();
        dac_dunf = 1'b1; clr_unf = 1'b1;
        tick();
        clr_unf = 1'b0; dac_dunf = 1'b0;
        tick();

        // Counter saturation without stop, then async reset mid-RUN.
        unf_stop = 1'b0; dac_dunf = 1'b1;
        repeat (20) tick();
        dac_dunf = 1'b0;
        tick();
        async_reset_check();
        repeat (2) tick();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            arm         = ($urandom_range(0, 7) == 0);
            disarm      = ($urandom_range(0, 39) == 0);
            clr_unf     = ($urandom_range(0, 49) == 0);
            ext_sync_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) ext_sync = ~ext_sync;
            start_delay = 8'($urandom_range(0, 4));
            unf_stop    = ($urandom_range(0, 1) == 0);
            dac_dunf    = ($urandom_range(0, 5) != 0);
            link_ready  = ($urandom_range(0, 7) != 0);
            tick();
        end

        @(negedge link_clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_start_ctrl.md
AD_IP_JESD204_TPL_DAC_START_CTRL -- requirements
Module: ad_ip_jesd204_tpl_dac_start_ctrl

Interface
REQ-001 SHALL have parameter SYNC_CYCLES, default 4, dac_sync pulse length in cycles (1..255).
REQ-002 SHALL have parameter UNF_LIMIT, default 16, consecutive-underflow cycles that trip the fault (1..255).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, underflow counter width.
REQ-004 SHALL use one clock and an asynchronous active-low reset. Ports are listed below, clock and reset first.
REQ-005 link_clk  in  1  single clock; all logic rising-edge.
REQ-006 link_resetn  in  1  asynchronous active-low reset.
REQ-007 arm  in  1  one-cycle start request.
REQ-008 disarm  in  1  one-cycle stop request.
REQ-009 ext_sync_en  in  1  1 = wait for external trigger edge after arm.
REQ-010 ext_sync  in  1  external trigger level, already synchronous to link_clk.
REQ-011 start_delay  in  8  cycles between dac_sync end and data enable.
REQ-012 unf_stop  in  1  1 = underflow fault stops transfer.
REQ-013 clr_unf  in  1  one-cycle clear of unf_count and unf_fault.
REQ-014 link_ready  in  1  JESD link accepting data.
REQ-015 dac_dunf  in  1  DMA underflow indication.
REQ-016 dac_sync  out  1  datapath/DDS phase resynchronisation.
REQ-017 data_gate  out  1  enables datapath output toward link.
REQ-018 state  out  3  current FSM state encoding.
REQ-019 unf_count  out  CNT_WIDTH  saturating underflow cycle count.
REQ-020 unf_fault  out  1  sticky consecutive-underflow fault.

Function
REQ-021 SHALL implement FSM with states IDLE=0, ARMED=1, SYNC=2, DELAY=3, RUN=4; the state output is the state register.
REQ-022 IDLE: arm=1 with ext_sync_en=1 -> ARMED; arm=1 with ext_sync_en=0 -> SYNC; otherwise stay.
REQ-023 ARMED: rising edge of ext_sync (ext_sync=1 and previous-cycle ext_sync=0) -> SYNC. The previous-cycle register samples every cycle in all states.
REQ-024 SYNC: stay exactly SYNC_CYCLES cycles. Exit to DELAY if start_delay!=0, else to RUN. start_delay is captured on SYNC exit.
REQ-025 DELAY: stay exactly the captured start_delay cycles, then -> RUN.
REQ-026 RUN: stay until disarm or underflow fault.
REQ-027 disarm=1 in any non-IDLE state -> IDLE next cycle. disarm has priority over arm and over all other transitions.
REQ-028 arm in any state other than IDLE SHALL be ignored.
REQ-029 dac_sync SHALL be 1 exactly while state==SYNC. data_gate SHALL be 1 exactly while state==RUN. Both are decoded from registered state with no combinational input path.
REQ-030 Latency: arm in IDLE (ext_sync_en=0) at edge N -> dac_sync high at edges N+1..N+SYNC_CYCLES; with start_delay=0, data_gate high from edge N+SYNC_CYCLES+1.
REQ-031 unf_count SHALL increment by 1 each RUN cycle with dac_dunf=1 and link_ready=1, and saturate at 2^CNT_WIDTH-1.
REQ-032 A consecutive counter SHALL increment on each RUN cycle with dac_dunf and link_ready high. It returns to 0 on any other cycle and on leaving RUN.
REQ-033 When the consecutive counter reaches UNF_LIMIT: unf_fault set to 1; if unf_stop=1 the FSM also goes RUN -> IDLE next cycle; if unf_stop=0 it stays in RUN.
REQ-034 clr_unf=1 SHALL zero unf_count, unf_fault and the consecutive counter. It wins over a simultaneous increment.
REQ-035 unf_count and unf_fault SHALL hold their values across state changes; only clr_unf or reset clears them.

Reset
REQ-036 While link_resetn=0: state=IDLE, dac_sync=0, data_gate=0, unf_count=0, unf_fault=0, all internal counters and the ext_sync history register = 0.
REQ-037 Reset assertion mid-operation (any state) SHALL force the REQ-036 values immediately, without waiting for a clock edge.
REQ-038 After reset release, the FSM SHALL start operating on the first link_clk edge.

Verification
REQ-039 Defaults, ext_sync_en=0, start_delay=0: arm pulse -> dac_sync high 4 cycles, then data_gate=1 on the next cycle; state sequence 0,2,4.
REQ-040 ext_sync_en=1, ext_sync held 1 before arm: no edge, stays ARMED; ext_sync 0 then 1 -> SYNC one cycle after the rising edge.
REQ-041 start_delay=3: DELAY lasts 3 cycles. Change start_delay to 9 during DELAY -> still 3 cycles.
REQ-042 RUN, unf_stop=1: dac_dunf=1, link_ready=1 for 16 cycles -> unf_count=16, unf_fault=1, IDLE next cycle. Repeat with a one-cycle gap at cycle 10 -> no fault.
REQ-043 arm and disarm same cycle in IDLE -> stays IDLE. disarm during SYNC -> IDLE and dac_sync=0 next cycle. clr_unf coincident with an underflow -> unf_count=0.
REQ-044 Assert link_resetn=0 mid-RUN -> data_gate=0 and state=0 with no clock edge. CNT_WIDTH=4 with 20 underflows and unf_stop=0 -> unf_count=15.
